// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: register mode codes and FSM states.
package shift_seq_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/shift_seq_reg.sv
// Shift-register datapath: hold, zero-fill shift right/left, or parallel load per mode.
module shift_seq_reg
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dout_q, dout_d;

  // Next register value selected by mode
  always_comb begin
    dout_d = dout_q;
    case (mode)
      MODE_LOAD: dout_d = load_data;
      MODE_SHR:  dout_d = {1'b0, dout_q[WIDTH-1:1]};
      MODE_SHL:  dout_d = {dout_q[WIDTH-2:0], 1'b0};
      MODE_HOLD: dout_d = dout_q;
      default:   dout_d = dout_q;
    endcase
  end

  // Shift register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven shift sequencer: LOAD, count SHIFT cycles, one-cycle DONE.
// Define SHIFT_SEQ_CMD_FIFO_EN for a 2-entry command FIFO accepting while busy.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             dir;
    logic [CNT_W-1:0] count;
  } cmd_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             rdy_en_q;
  logic             accept_s;
  logic             more_s;
  cmd_t             in_s;
  cmd_t             head_s;

  assign in_s     = {cmd_data, cmd_dir, cmd_count};
  assign accept_s = cmd_valid && cmd_ready;

`ifdef SHIFT_SEQ_CMD_FIFO_EN
  // The executing command stays at the FIFO head until its DONE cycle retires it.
  cmd_t       fifo_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] cnt_q;
  logic       pop_s;

  assign pop_s     = (state_q == DONE);
  assign head_s    = fifo_q[rd_ptr_q];
  assign cmd_ready = rdy_en_q && !abort && (cnt_q != 2'd2);
  assign more_s    = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && accept_s);

  // Command FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else if (abort) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (accept_s) begin
        fifo_q[wr_ptr_q] <= in_s;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, accept_s} - {1'b0, pop_s};
    end
  end
`else
  cmd_t cmd_q;

  assign head_s    = cmd_q;
  assign cmd_ready = rdy_en_q && !abort && (state_q == IDLE);
  assign more_s    = 1'b0;

  // Single captured command, only written while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q <= '0;
    end else if (accept_s) begin
      cmd_q <= in_s;
    end
  end
`endif

  // Holds off cmd_ready until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  // FSM state and remaining-shift counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state and register mode; abort freezes dout and returns to IDLE
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode    = MODE_HOLD;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          mode  = MODE_LOAD;
          rem_d = head_s.count;
          if (head_s.count != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
        SHIFT: begin
          mode  = head_s.dir ? MODE_SHL : MODE_SHR;
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
        DONE: begin
          if (more_s) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  shift_seq_reg #(
    .WIDTH(WIDTH)
  ) u_reg (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .load_data (head_s.data),
    .dout      (dout)
  );

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (default and SHIFT_SEQ_CMD_FIFO_EN builds).
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_data = 4'b0000;
  logic       cmd_dir = 1'b0;
  logic [2:0] cmd_count = 3'd0;
  logic       abort = 1'b0;
  logic [1:0] mode;
  logic [3:0] dout;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

`ifdef SHIFT_SEQ_CMD_FIFO_EN
  localparam logic READY_BUSY = 1'b1;
`else
  localparam logic READY_BUSY = 1'b0;
`endif

  shift_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_dir   (cmd_dir),
    .cmd_count (cmd_count),
    .abort     (abort),
    .mode      (mode),
    .dout      (dout),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_vec++; if (dout !== 4'b0000) begin n_err++; $display("FAIL rst_dout: got %b expected 0000", dout); end
    n_vec++; if (mode !== 2'b00) begin n_err++; $display("FAIL rst_mode: got %b expected 00", mode); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_busy_done: got %b%b expected 00", busy, done); end
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", cmd_ready); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b expected 1", cmd_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_after: got %b expected 0", busy); end
  endtask

  // seq nibble k = dout expected during cycle k+1 after the accept edge
  task automatic run_cmd(input logic [3:0] data, input logic dir, input logic [2:0] cnt,
                         input logic [31:0] seq, input string name);
    int         c;
    logic [1:0] em;
    c = int'(cnt);
    cmd_data = data; cmd_dir = dir; cmd_count = cnt; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k <= c + 1; k++) begin
      if (k == 0) em = 2'b11;
      else if (k <= c) em = dir ? 2'b10 : 2'b01;
      else em = 2'b00;
      n_vec++; if (mode !== em) begin n_err++; $display("FAIL %s_mode c%0d: got %b expected %b", name, k, mode, em); end
      n_vec++; if (done !== (k == c + 1)) begin n_err++; $display("FAIL %s_done c%0d: got %b expected %b", name, k, done, (k == c + 1)); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy c%0d: got %b expected 1", name, k, busy); end
      n_vec++; if (cmd_ready !== READY_BUSY) begin n_err++; $display("FAIL %s_ready c%0d: got %b expected %b", name, k, cmd_ready, READY_BUSY); end
      if (k >= 1) begin
        n_vec++; if (dout !== seq[4*(k-1) +: 4]) begin n_err++; $display("FAIL %s_dout c%0d: got %b expected %b", name, k, dout, seq[4*(k-1) +: 4]); end
      end
      tick();
    end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL %s_idle: got busy=%b done=%b expected 0 0", name, busy, done); end
    n_vec++; if (dout !== seq[4*c +: 4]) begin n_err++; $display("FAIL %s_final: got %b expected %b", name, dout, seq[4*c +: 4]); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready_idle: got %b expected 1", name, cmd_ready); end
  endtask

  task automatic test_shift_left();
    run_cmd(4'b0001, 1'b1, 3'd3, 32'h0000_8421, "shl3");
  endtask

  task automatic test_shift_right();
    run_cmd(4'b1101, 1'b0, 3'd2, 32'h0000_036D, "shr2");
  endtask

  task automatic test_load_only();
    run_cmd(4'b1010, 1'b0, 3'd0, 32'h0000_000A, "load0");
  endtask

  task automatic test_overshift();
    run_cmd(4'b1111, 1'b1, 3'd7, 32'h0000_8CEF, "shl7");
    run_cmd(4'b1000, 1'b0, 3'd4, 32'h0000_1248, "shr4");
  endtask

  task automatic test_abort();
    cmd_data = 4'b0001; cmd_dir = 1'b1; cmd_count = 3'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    n_vec++; if (dout !== 4'b0010) begin n_err++; $display("FAIL abort_pre_dout: got %b expected 0010", dout); end
    abort = 1'b1;
    cmd_data = 4'b1111; cmd_count = 3'd0; cmd_valid = 1'b1;
    #1;
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b expected 0", cmd_ready); end
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_vec++; if (dout !== 4'b0010) begin n_err++; $display("FAIL abort_dout: got %b expected 0010", dout); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_quiet c%0d: got done=%b busy=%b expected 0 0", k, done, busy); end
      n_vec++; if (dout !== 4'b0010) begin n_err++; $display("FAIL abort_hold c%0d: got %b expected 0010", k, dout); end
    end
  endtask

  task automatic test_reset_mid();
    cmd_data = 4'b0001; cmd_dir = 1'b1; cmd_count = 3'd3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (dout !== 4'b0000) begin n_err++; $display("FAIL rstmid_dout: got %b expected 0000", dout); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got busy=%b done=%b expected 0 0", busy, done); end
    n_vec++; if (mode !== 2'b00 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_mode_ready: got %b %b expected 00 0", mode, cmd_ready); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet c%0d: got done=%b busy=%b expected 0 0", k, done, busy); end
    end
  endtask

`ifdef SHIFT_SEQ_CMD_FIFO_EN
  task automatic test_back_to_back();
    cmd_data = 4'b0001; cmd_dir = 1'b1; cmd_count = 3'd1; cmd_valid = 1'b1;
    tick();
    n_vec++; if (mode !== 2'b11 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL fifo_c0: got mode=%b ready=%b expected 11 1", mode, cmd_ready); end
    cmd_data = 4'b1000; cmd_dir = 1'b0; cmd_count = 3'd1;
    tick();
    cmd_data = 4'b1111; cmd_dir = 1'b0; cmd_count = 3'd0;
    n_vec++; if (mode !== 2'b10 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL fifo_c1: got mode=%b ready=%b expected 10 0", mode, cmd_ready); end
    tick();
    n_vec++; if (done !== 1'b1 || dout !== 4'b0010 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL fifo_c2: got done=%b dout=%b ready=%b expected 1 0010 0", done, dout, cmd_ready); end
    tick();
    n_vec++; if (busy !== 1'b1 || mode !== 2'b11 || done !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL fifo_c3: got busy=%b mode=%b done=%b ready=%b expected 1 11 0 1", busy, mode, done, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    n_vec++; if (mode !== 2'b01 || dout !== 4'b1000) begin n_err++; $display("FAIL fifo_c4: got mode=%b dout=%b expected 01 1000", mode, dout); end
    tick();
    n_vec++; if (done !== 1'b1 || dout !== 4'b0100) begin n_err++; $display("FAIL fifo_c5: got done=%b dout=%b expected 1 0100", done, dout); end
    tick();
    n_vec++; if (busy !== 1'b1 || mode !== 2'b11 || done !== 1'b0) begin n_err++; $display("FAIL fifo_c6: got busy=%b mode=%b done=%b expected 1 11 0", busy, mode, done); end
    tick();
    n_vec++; if (done !== 1'b1 || dout !== 4'b1111) begin n_err++; $display("FAIL fifo_c7: got done=%b dout=%b expected 1 1111", done, dout); end
    tick();
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL fifo_c8: got busy=%b done=%b expected 0 0", busy, done); end
  endtask
`else
  task automatic test_back_to_back();
    cmd_data = 4'b0101; cmd_dir = 1'b0; cmd_count = 3'd0; cmd_valid = 1'b1;
    tick();
    cmd_data = 4'b0011; cmd_dir = 1'b1; cmd_count = 3'd1;
    n_vec++; if (mode !== 2'b11 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_c0: got mode=%b ready=%b expected 11 0", mode, cmd_ready); end
    tick();
    n_vec++; if (done !== 1'b1 || dout !== 4'b0101 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_c1: got done=%b dout=%b ready=%b expected 1 0101 0", done, dout, cmd_ready); end
    tick();
    n_vec++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_c2: got busy=%b ready=%b expected 0 1", busy, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    n_vec++; if (mode !== 2'b11 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_c3: got mode=%b busy=%b expected 11 1", mode, busy); end
    tick();
    n_vec++; if (mode !== 2'b10 || dout !== 4'b0011) begin n_err++; $display("FAIL b2b_c4: got mode=%b dout=%b expected 10 0011", mode, dout); end
    tick();
    n_vec++; if (done !== 1'b1 || dout !== 4'b0110) begin n_err++; $display("FAIL b2b_c5: got done=%b dout=%b expected 1 0110", done, dout); end
    tick();
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL b2b_c6: got busy=%b done=%b expected 0 0", busy, done); end
  endtask
`endif

  initial begin
    test_reset();
    test_shift_left();
    test_shift_right();
    test_load_only();
    test_overshift();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_shift_left();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
